// File: rtl/next_pc_unit.sv
// Program-counter sequencer for the single-cycle RV32I core: selects sequential,
// branch or jump flow, traps on misaligned targets and counts retired/taken branches.
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             IsBranch,
  input  logic             IsJump,
  input  logic             NextPCSrc,
  input  logic [31:0]      Target,
  input  logic             Resume,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Redirect,
  output logic             MisalignTrap,
  output logic [31:0]      TrapPC,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [31:0]      pc_nxt, trap_pc_nxt, eff_target;
  logic [CNT_W-1:0] bcnt_nxt, tcnt_nxt;
  logic             take, is_cond, misaligned;
  logic             unused_target_lsb;

  // Jump wins when both decode flags are set, so only pure branches are counted.
  assign take       = IsJump | (IsBranch & NextPCSrc);
  assign is_cond    = IsBranch & ~IsJump;
  assign misaligned = Target[1];
  assign eff_target = {Target[31:1], 1'b0};
  assign unused_target_lsb = Target[0];

  assign PCPlus4      = PC + 32'd4;
  assign MisalignTrap = (state == TRAP);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = PC;
    trap_pc_nxt = TrapPC;
    bcnt_nxt    = BranchCnt;
    tcnt_nxt    = TakenCnt;
    Redirect    = 1'b0;
    case (state)
      RUN: begin
        if (!Stall) begin
          if (is_cond) bcnt_nxt = BranchCnt + CNT_ONE;
          if (is_cond & NextPCSrc & ~misaligned) tcnt_nxt = TakenCnt + CNT_ONE;
          if (take & misaligned) begin
            state_nxt   = TRAP;
            trap_pc_nxt = PC;
          end else if (take) begin
            pc_nxt   = eff_target;
            Redirect = ~rst;
          end else begin
            pc_nxt = PCPlus4;
          end
        end
      end
      TRAP: begin
        // Resume skips the faulting instruction.
        if (Resume) begin
          pc_nxt    = TrapPC + 32'd4;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      PC        <= RESET_VECTOR;
      TrapPC    <= 32'd0;
      BranchCnt <= '0;
      TakenCnt  <= '0;
    end else begin
      state     <= state_nxt;
      PC        <= pc_nxt;
      TrapPC    <= trap_pc_nxt;
      BranchCnt <= bcnt_nxt;
      TakenCnt  <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed steps followed by randomized
// cycles, all compared against a behavioural model of the sequencer.
module tb_next_pc_unit;

  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int          CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, Stall, IsBranch, IsJump, NextPCSrc, Resume;
  logic [31:0]      Target;
  logic [31:0]      PC, PCPlus4, TrapPC;
  logic             Redirect, MisalignTrap;
  logic [CNT_W-1:0] BranchCnt, TakenCnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_pc, m_tpc;
  bit          m_trap;
  int          m_b, m_t;

  next_pc_unit #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .IsBranch(IsBranch), .IsJump(IsJump),
    .NextPCSrc(NextPCSrc), .Target(Target), .Resume(Resume),
    .PC(PC), .PCPlus4(PCPlus4), .Redirect(Redirect), .MisalignTrap(MisalignTrap),
    .TrapPC(TrapPC), .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, check state.
  task automatic cyc(input logic r, input logic st, input logic ib, input logic ij,
                     input logic ns, input logic [31:0] tg, input logic rs);
    bit take, mis, exp_redir;
    rst = r; Stall = st; IsBranch = ib; IsJump = ij; NextPCSrc = ns; Target = tg; Resume = rs;
    take = ij || (ib && ns);
    mis  = tg[1];
    #1;
    if (m_valid) begin
      exp_redir = !r && !m_trap && !st && take && !mis;
      chk("redirect", {31'd0, Redirect}, {31'd0, exp_redir});
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b1; m_pc = RV; m_trap = 1'b0; m_tpc = 32'd0; m_b = 0; m_t = 0;
    end else if (m_valid) begin
      if (m_trap) begin
        if (rs) begin m_pc = m_tpc + 32'd4; m_trap = 1'b0; end
      end else if (!st) begin
        if (ib && !ij) m_b = (m_b + 1) % (1 << CNT_W);
        if (ib && !ij && ns && !mis) m_t = (m_t + 1) % (1 << CNT_W);
        if (take && mis) begin m_trap = 1'b1; m_tpc = m_pc; end
        else if (take) m_pc = tg & 32'hFFFF_FFFE;
        else m_pc = m_pc + 32'd4;
      end
    end
    if (m_valid) begin
      chk("pc", PC, m_pc);
      chk("trap", {31'd0, MisalignTrap}, {31'd0, m_trap});
      chk("trappc", TrapPC, m_tpc);
      chk("branchcnt", 32'(BranchCnt), 32'(m_b));
      chk("takencnt", 32'(TakenCnt), 32'(m_t));
    end
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; IsBranch = 1'b0; IsJump = 1'b0;
    NextPCSrc = 1'b0; Target = 32'd0; Resume = 1'b0;

    // Reset and sequential flow
    cyc(1, 0, 0, 0, 0, 32'd0, 0);
    cyc(1, 0, 0, 0, 0, 32'd0, 0);
    chk("rst_pc", PC, 32'h1000);
    chk("rst_pcplus4", PCPlus4, 32'h1004);
    chk("rst_bcnt", 32'(BranchCnt), 32'd0);
    chk("rst_tcnt", 32'(TakenCnt), 32'd0);
    chk("rst_trap", {31'd0, MisalignTrap}, 32'd0);
    cyc(0, 0, 0, 0, 0, 32'd0, 0); chk("seq_1004", PC, 32'h1004);
    cyc(0, 0, 0, 0, 0, 32'd0, 0); chk("seq_1008", PC, 32'h1008);
    cyc(0, 0, 0, 0, 0, 32'd0, 0); chk("seq_100c", PC, 32'h100C);
    chk("seq_pcplus4", PCPlus4, 32'h1010);

    // Branch taken vs not taken
    cyc(0, 0, 0, 1, 0, 32'h100, 0); chk("jmp_100", PC, 32'h100);
    cyc(0, 0, 1, 0, 1, 32'h40, 0);
    chk("br_taken_pc", PC, 32'h40);
    chk("br_taken_b", 32'(BranchCnt), 32'd1);
    chk("br_taken_t", 32'(TakenCnt), 32'd1);
    cyc(0, 0, 1, 0, 0, 32'h40, 0);
    chk("br_nt_pc", PC, 32'h44);
    chk("br_nt_b", 32'(BranchCnt), 32'd2);
    chk("br_nt_t", 32'(TakenCnt), 32'd1);

    // JALR bit clearing with jump priority
    cyc(0, 0, 1, 1, 1, 32'h201, 0);
    chk("jalr_pc", PC, 32'h200);
    chk("jalr_b", 32'(BranchCnt), 32'd2);
    chk("jalr_t", 32'(TakenCnt), 32'd1);

    // Misaligned trap, ignored inputs in TRAP, resume
    cyc(0, 0, 0, 1, 0, 32'h80, 0);
    cyc(0, 0, 1, 0, 1, 32'h0A, 0);
    chk("trap_flag", {31'd0, MisalignTrap}, 32'd1);
    chk("trap_pc", TrapPC, 32'h80);
    chk("trap_pc_hold", PC, 32'h80);
    chk("trap_b", 32'(BranchCnt), 32'd3);
    chk("trap_t", 32'(TakenCnt), 32'd1);
    cyc(0, 1, 1, 1, 1, 32'h300, 0);
    chk("trap_ignore_pc", PC, 32'h80);
    cyc(0, 0, 0, 0, 0, 32'd0, 1);
    chk("resume_pc", PC, 32'h84);
    chk("resume_flag", {31'd0, MisalignTrap}, 32'd0);

    // Stall freezes a pending taken branch
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 1, 32'h500, 0);
      chk("stall_pc", PC, 32'h84);
    end
    cyc(0, 0, 1, 0, 1, 32'h500, 0);
    chk("stall_release_pc", PC, 32'h500);
    chk("stall_release_b", 32'(BranchCnt), 32'd4);
    chk("stall_release_t", 32'(TakenCnt), 32'd2);

    // Counter wrap at CNT_W = 4
    cyc(1, 0, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, 0, 32'h40, 0);
    chk("wrap_b", 32'(BranchCnt), 32'd1);
    chk("wrap_pc", PC, 32'h1044);

    // Reset wins over Resume while trapped
    cyc(0, 0, 0, 1, 0, 32'h2, 0);
    chk("trap2_flag", {31'd0, MisalignTrap}, 32'd1);
    cyc(1, 0, 0, 0, 0, 32'd0, 1);
    chk("rst_trap_pc", PC, RV);
    chk("rst_trap_flag", {31'd0, MisalignTrap}, 32'd0);
    chk("rst_trap_b", 32'(BranchCnt), 32'd0);
    chk("rst_trap_t", 32'(TakenCnt), 32'd0);
    chk("rst_trap_tpc", TrapPC, 32'd0);

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1] = 1'b0;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
          1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), tg,
          ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter sequencer for the single-cycle RV32I core; consumes the branch-resolution flag (`NextPCSrc`) and the computed target, and owns the `PC` register. Each cycle it selects sequential, branch or jump flow. It detects misaligned control-transfer targets and holds in a trap state until released. It also keeps retired-branch and taken-branch counters for performance monitoring.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: `PC` value after reset.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `Stall`, in, 1: hold `PC` and counters this cycle.
- `IsBranch`, in, 1: current instruction is a conditional branch.
- `IsJump`, in, 1: current instruction is JAL or JALR.
- `NextPCSrc`, in, 1: branch condition met, from the branch comparator.
- `Target`, in, 32: computed branch or jump target.
- `Resume`, in, 1: leave the trap state.
- `PC`, out, 32: current instruction address (registered).
- `PCPlus4`, out, 32: `PC` + 4, combinational, for link writeback.
- `Redirect`, out, 1: combinational; control transfer accepted this cycle.
- `MisalignTrap`, out, 1: registered; high while in TRAP.
- `TrapPC`, out, 32: registered; `PC` of the faulting instruction.
- `BranchCnt`, out, `CNT_W`: registered; retired conditional branches.
- `TakenCnt`, out, `CNT_W`: registered; taken conditional branches that redirected.

## Operation
- States: RUN, TRAP. Reset enters RUN.
- Control decode:
  - take = `IsJump` | (`IsBranch` & `NextPCSrc`).
  - When `IsJump` and `IsBranch` are both high, the instruction is treated as a jump; `BranchCnt` and `TakenCnt` do not increment.
- Effective target = {`Target`[31:1], 1'b0`}; bit 0 is always cleared, as JALR requires.
- The target is misaligned iff `Target`[1] = 1. There is no C extension.
- In RUN with `Stall` = 0:
  - take & ~misaligned: `PC` ← effective target; `Redirect` = 1.
  - take & misaligned: state → TRAP; `TrapPC` ← `PC`; `PC` holds; `Redirect` = 0.
  - otherwise: `PC` ← `PC` + 4, wrapping modulo 2^32.
  - `BranchCnt` += 1 when `IsBranch` & ~`IsJump`, including a trapping branch.
  - `TakenCnt` += 1 when `IsBranch` & ~`IsJump` & `NextPCSrc` & ~misaligned.
- In RUN with `Stall` = 1: all state holds; `Redirect` = 0.
- In TRAP:
  - `PC`, the counters and `TrapPC` hold.
  - `IsBranch`, `IsJump`, `NextPCSrc` and `Stall` are ignored.
  - `Redirect` = 0.
  - `Resume` = 1: `PC` ← `TrapPC` + 4, skipping the faulting instruction; state → RUN.
- `Resume` in RUN is ignored.
- Counters wrap from 2^`CNT_W` − 1 to 0 with no saturation or flag.
- `MisalignTrap` = 1 exactly when the state is TRAP.

## Timing
- Reset values:
  - `PC` = `RESET_VECTOR`.
  - `PCPlus4` = `RESET_VECTOR` + 4.
  - `Redirect` = 0, `MisalignTrap` = 0.
  - `TrapPC` = 0, `BranchCnt` = 0, `TakenCnt` = 0.
- `rst` takes priority over every other input, including mid-TRAP and when coincident with `Resume`.
- Next-PC latency is one cycle: a decision made in cycle N is visible on `PC` in cycle N+1.
- `Redirect` and `PCPlus4` are combinational from the current-cycle inputs and `PC`. There is no registered path from `Target` to `Redirect`.
- TRAP entry is one cycle after the faulting decision: `MisalignTrap` rises in cycle N+1.
- TRAP exit: `Resume` sampled in cycle M gives `PC` = `TrapPC` + 4 and `MisalignTrap` = 0 in cycle M+1.
- Counter values are visible one cycle after the qualifying instruction.

## Test plan
- Reset and sequential flow: assert `rst` for 2 cycles with `RESET_VECTOR` = 32'h0000_1000, then 3 idle cycles. `PC` must be 1000, 1004, 1008, 100C; `PCPlus4` must be `PC` + 4; both counters must be 0.
- Branch taken versus not taken:
  - At `PC` = 0x100, `IsBranch` = 1, `NextPCSrc` = 1, `Target` = 0x40 → `Redirect` = 1, next `PC` = 0x40, `BranchCnt` = 1, `TakenCnt` = 1.
  - Then `NextPCSrc` = 0 → `PC` = 0x44, `BranchCnt` = 2, `TakenCnt` = 1.
- JALR bit clearing and jump priority: `IsJump` = 1, `IsBranch` = 1, `Target` = 0x201 → next `PC` = 0x200, counters unchanged.
- Misaligned trap and resume:
  - At `PC` = 0x80, a taken branch with `Target` = 0x0A → `MisalignTrap` = 1 and `TrapPC` = 0x80 next cycle; `PC` stays 0x80 and `BranchCnt` += 1, `TakenCnt` unchanged.
  - While in TRAP, `Stall` = 1 and a taken jump are applied → no change.
  - `Resume` = 1 → `PC` = 0x84, `MisalignTrap` = 0.
- Stall: a taken branch with `Stall` = 1 for 3 cycles → `PC` and counters frozen and `Redirect` = 0; releasing `Stall` applies the branch on the next edge.
- Counter wrap and reset in TRAP:
  - With `CNT_W` = 4, retire 17 branches → `BranchCnt` = 1.
  - Enter TRAP, then assert `rst` together with `Resume` → `PC` = `RESET_VECTOR`, `MisalignTrap` = 0, all counters 0.
